// File: rtl/rv32i_types_pkg.sv
// Shared RV32I word/register/ALU-op types used by decode, ID/EX and forwarding.
package rv32i_types;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] rv32i_word;
  typedef logic [4:0]      rv32i_reg;

  typedef enum logic [2:0] {
    alu_add = 3'd0,
    alu_sll = 3'd1,
    alu_sra = 3'd2,
    alu_sub = 3'd3,
    alu_xor = 3'd4,
    alu_srl = 3'd5,
    alu_or  = 3'd6,
    alu_and = 3'd7
  } alu_ops;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard equation: the instruction in ID reads the rd of a load sitting in EX.
module load_use_detect
  import rv32i_types::*;
(
  input  logic     exe_valid,
  input  logic     exe_mem_read,
  input  rv32i_reg exe_rd,
  input  logic     id_valid,
  input  rv32i_reg id_rs1,
  input  rv32i_reg id_rs2,
  input  logic     id_uses_rs1,
  input  logic     id_uses_rs2,
  output logic     hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == exe_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == exe_rd);

  // x0 is never really written, so a load targeting it cannot create a dependency
  assign hazard = exe_valid && exe_mem_read && (exe_rd != 5'd0) && id_valid
                  && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, memory stall and bubble counter.
module id_ex_stage
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_load_regfile,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  alu_ops           id_aluop,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             stall_mem,
  input  logic             flush,
  output logic             exe_valid,
  output logic [XLEN-1:0]  exe_pc,
  output logic [XLEN-1:0]  exe_imm,
  output logic [4:0]       exe_rs1,
  output logic [4:0]       exe_rs2,
  output logic [4:0]       exe_rd,
  output logic             exe_load_regfile,
  output logic             exe_mem_read,
  output logic             exe_mem_write,
  output alu_ops           exe_aluop,
  output logic             id_stall,
  output logic [CNT_W-1:0] hazard_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d, imm_q, imm_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic             lrf_q, lrf_d, mrd_q, mrd_d, mwr_q, mwr_d;
  alu_ops           aluop_q, aluop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;

  load_use_detect u_detect (
    .exe_valid   (valid_q),
    .exe_mem_read(mrd_q),
    .exe_rd      (rd_q),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .hazard      (hazard)
  );

  // Memory stall freezes IF/ID directly at the top level, so it suppresses id_stall here
  assign id_stall = hazard && !flush && !stall_mem;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    lrf_d   = lrf_q;
    mrd_d   = mrd_q;
    mwr_d   = mwr_q;
    aluop_d = aluop_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      lrf_d   = 1'b0;
      mrd_d   = 1'b0;
      mwr_d   = 1'b0;
    end else if (stall_mem) begin
      cnt_d = cnt_q;
    end else if (hazard) begin
      // Bubble: data fields keep their old (don't-care) values
      valid_d = 1'b0;
      lrf_d   = 1'b0;
      mrd_d   = 1'b0;
      mwr_d   = 1'b0;
      cnt_d   = sat_inc(cnt_q);
    end else begin
      valid_d = id_valid;
      pc_d    = id_pc;
      imm_d   = id_imm;
      rs1_d   = id_rs1;
      rs2_d   = id_rs2;
      rd_d    = id_rd;
      lrf_d   = id_load_regfile && id_valid;
      mrd_d   = id_mem_read && id_valid;
      mwr_d   = id_mem_write && id_valid;
      aluop_d = id_aluop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      lrf_q   <= 1'b0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      aluop_q <= alu_add;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      lrf_q   <= lrf_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      aluop_q <= aluop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign exe_valid        = valid_q;
  assign exe_pc           = pc_q;
  assign exe_imm          = imm_q;
  assign exe_rs1          = rs1_q;
  assign exe_rs2          = rs2_q;
  assign exe_rd           = rd_q;
  assign exe_load_regfile = lrf_q;
  assign exe_mem_read     = mrd_q;
  assign exe_mem_write    = mwr_q;
  assign exe_aluop        = aluop_q;
  assign hazard_count     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second narrow-counter instance covers saturation.
module tb_id_ex_stage;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_load_regfile, id_mem_read, id_mem_write;
  logic [31:0] id_pc, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  alu_ops      id_aluop;
  logic        stall_mem, flush;

  logic        exe_valid, exe_load_regfile, exe_mem_read, exe_mem_write, id_stall;
  logic [31:0] exe_pc, exe_imm;
  logic [4:0]  exe_rs1, exe_rs2, exe_rd;
  alu_ops      exe_aluop;
  logic [15:0] hazard_count;

  logic        b_valid, b_lrf, b_mrd, b_mwr, b_stall;
  logic [31:0] b_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  alu_ops      b_aluop;
  logic [1:0]  b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_load_regfile(id_load_regfile), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_aluop(id_aluop), .id_imm(id_imm), .stall_mem(stall_mem), .flush(flush),
    .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_imm(exe_imm),
    .exe_rs1(exe_rs1), .exe_rs2(exe_rs2), .exe_rd(exe_rd),
    .exe_load_regfile(exe_load_regfile), .exe_mem_read(exe_mem_read), .exe_mem_write(exe_mem_write),
    .exe_aluop(exe_aluop), .id_stall(id_stall), .hazard_count(hazard_count)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_load_regfile(id_load_regfile), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_aluop(id_aluop), .id_imm(id_imm), .stall_mem(stall_mem), .flush(flush),
    .exe_valid(b_valid), .exe_pc(b_pc), .exe_imm(b_imm),
    .exe_rs1(b_rs1), .exe_rs2(b_rs2), .exe_rd(b_rd),
    .exe_load_regfile(b_lrf), .exe_mem_read(b_mrd), .exe_mem_write(b_mwr),
    .exe_aluop(b_aluop), .id_stall(b_stall), .hazard_count(b_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                        input logic u2, input logic lrf, input logic mr, input logic mw,
                        input logic [2:0] op);
    id_valid = v; id_pc = pc; id_imm = pc ^ 32'h0000_1000;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_load_regfile = lrf; id_mem_read = mr; id_mem_write = mw;
    id_aluop = alu_ops'(op);
  endtask

  initial begin
    rst_n = 1'b0; stall_mem = 1'b0; flush = 1'b0;
    set_id(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0);
    tick(); tick();
    check("rst_valid", {31'd0, exe_valid}, 32'd0);
    check("rst_count", {16'd0, hazard_count}, 32'd0);
    check("rst_stall", {31'd0, id_stall}, 32'd0);
    rst_n = 1'b1;

    // Pass-through
    set_id(1, 32'h60, 1, 2, 5, 1, 1, 1, 0, 0, 3'd3);
    #1 check("pt_stall", {31'd0, id_stall}, 32'd0);
    tick();
    check("pt_pc", exe_pc, 32'h60);
    check("pt_imm", exe_imm, 32'h1060);
    check("pt_rd", {27'd0, exe_rd}, 32'd5);
    check("pt_valid", {31'd0, exe_valid}, 32'd1);
    check("pt_aluop", {29'd0, exe_aluop}, 32'd3);
    check("pt_lrf", {31'd0, exe_load_regfile}, 32'd1);

    // Invalid slot must not carry controls
    set_id(0, 32'h64, 0, 0, 6, 0, 0, 1, 1, 1, 3'd0);
    tick();
    check("inv_valid", {31'd0, exe_valid}, 32'd0);
    check("inv_lrf", {31'd0, exe_load_regfile}, 32'd0);
    check("inv_mw", {31'd0, exe_mem_write}, 32'd0);
    check("inv_mr", {31'd0, exe_mem_read}, 32'd0);

    // Load-use: lw x7 then add using x7
    set_id(1, 32'h64, 2, 0, 7, 1, 0, 1, 1, 0, 3'd0);
    tick();
    set_id(1, 32'h68, 7, 3, 8, 1, 1, 1, 0, 0, 3'd0);
    #1 check("lu_stall", {31'd0, id_stall}, 32'd1);
    tick();
    check("lu_bubble", {31'd0, exe_valid}, 32'd0);
    check("lu_count", {16'd0, hazard_count}, 32'd1);
    check("lu_bub_mr", {31'd0, exe_mem_read}, 32'd0);
    check("lu_stall_off", {31'd0, id_stall}, 32'd0);
    tick();
    check("lu_adv_valid", {31'd0, exe_valid}, 32'd1);
    check("lu_adv_rs1", {27'd0, exe_rs1}, 32'd7);
    check("lu_adv_pc", exe_pc, 32'h68);
    check("lu_adv_stall", {31'd0, id_stall}, 32'd0);

    // x0 load never stalls
    set_id(1, 32'h6c, 1, 0, 0, 0, 0, 1, 1, 0, 3'd0);
    tick();
    set_id(1, 32'h70, 0, 0, 9, 1, 0, 1, 0, 0, 3'd0);
    #1 check("x0_stall", {31'd0, id_stall}, 32'd0);
    tick();

    // Unused rs2 does not stall; store data on rs2 does
    set_id(1, 32'h74, 1, 0, 4, 0, 0, 1, 1, 0, 3'd0);
    tick();
    set_id(1, 32'h78, 1, 4, 10, 1, 0, 1, 0, 0, 3'd0);
    #1 check("unused_rs2", {31'd0, id_stall}, 32'd0);
    set_id(1, 32'h78, 1, 4, 0, 1, 1, 0, 0, 1, 3'd0);
    #1 check("store_rs2", {31'd0, id_stall}, 32'd1);

    // Flush beats hazard
    flush = 1'b1;
    #1 check("fl_stall", {31'd0, id_stall}, 32'd0);
    tick();
    flush = 1'b0;
    check("fl_valid", {31'd0, exe_valid}, 32'd0);
    check("fl_count", {16'd0, hazard_count}, 32'd1);
    check("fl_mr", {31'd0, exe_mem_read}, 32'd0);

    // stall_mem during a hazard
    set_id(1, 32'h80, 1, 0, 9, 0, 0, 1, 1, 0, 3'd0);
    tick();
    set_id(1, 32'h84, 9, 0, 11, 1, 0, 1, 0, 0, 3'd0);
    stall_mem = 1'b1;
    #1 check("sm_stall", {31'd0, id_stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sm_pc", exe_pc, 32'h80);
      check("sm_valid", {31'd0, exe_valid}, 32'd1);
      check("sm_mr", {31'd0, exe_mem_read}, 32'd1);
      check("sm_count", {16'd0, hazard_count}, 32'd1);
    end
    stall_mem = 1'b0;
    #1 check("sm_rel_stall", {31'd0, id_stall}, 32'd1);
    tick();
    check("sm_bubble", {31'd0, exe_valid}, 32'd0);
    check("sm_count2", {16'd0, hazard_count}, 32'd2);
    tick();
    check("sm_adv_pc", exe_pc, 32'h84);
    check("sm_adv_valid", {31'd0, exe_valid}, 32'd1);

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, exe_valid}, 32'd0);
    check("ar_pc", exe_pc, 32'd0);
    check("ar_rd", {27'd0, exe_rd}, 32'd0);
    check("ar_lrf", {31'd0, exe_load_regfile}, 32'd0);
    check("ar_count", {16'd0, hazard_count}, 32'd0);
    check("ar_stall", {31'd0, id_stall}, 32'd0);
    tick();
    check("ar_hold_valid", {31'd0, exe_valid}, 32'd0);
    rst_n = 1'b1;

    // Saturation on the 2-bit counter instance
    for (int i = 1; i <= 4; i++) begin
      set_id(1, 32'h100, 1, 0, 7, 0, 0, 1, 1, 0, 3'd0);
      tick();
      set_id(1, 32'h104, 7, 0, 8, 1, 0, 1, 0, 0, 3'd0);
      tick();
    end
    check("sat_wide", {16'd0, hazard_count}, 32'd4);
    check("sat_narrow", {30'd0, b_count}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
